// File: rtl/cpu_dmem_pkg.sv
// Shared definitions for the cpu_dmem data memory: request-field positions,
// access-size encodings and the load sign/zero-extension helper.
package cpu_dmem_pkg;

    localparam int CTRL_VALID = 0;
    localparam int CTRL_WRITE = 1;
    localparam int CTRL_F3_LO = 2;
    localparam int CTRL_F3_HI = 4;

    localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    // Input is already right-aligned; only the low 'sz' bytes are meaningful.
    function automatic logic [63:0] extend_load(input logic [63:0] d,
                                                input size_e       sz,
                                                input logic        zext);
        case (sz)
            SZ_BYTE: extend_load = zext ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            SZ_HALF: extend_load = zext ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            SZ_WORD: extend_load = zext ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: extend_load = d;
        endcase
    endfunction

endpackage

// File: rtl/cpu_dmem_lane.sv
// One byte-wide bank of the data memory: synchronous write, combinational read
// so the top can register the aligned/extended load result in a single stage.
module cpu_dmem_lane #(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the storage array is deliberately left out of reset; clearing it
    // would forbid RAM inference and contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cpu_dmem.sv
// Data-memory responder for the cpu_core load/store port: fault decode, byte-lane
// store masking, one-cycle registered load extract/extend, sticky error capture, host port.
module cpu_dmem
    import cpu_dmem_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     running,
    input  logic [4:0]               ram_ctrl,
    input  logic [ADDR_W-1:0]        ram_addr,
    input  logic [63:0]              ram_din,
    output logic [63:0]              ram_dout,
    input  logic                     host_en,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [63:0]              host_wdata,
    output logic [63:0]              host_rdata,
    output logic                     err_flag,
    output logic [ADDR_W-1:0]        err_addr,
    input  logic                     err_clr
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [2:0]       funct3;
    logic             valid, is_write, zext;
    size_e            size;
    logic [2:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       size_bytes;
    logic [2:0]       align_mask;
    logic             misaligned, out_of_range, bad_funct3, fault;
    logic             core_store, core_load, host_act;
    logic [7:0]       byte_mask, lane_mask;
    logic [63:0]      store_data, rd_data, load_ext;

    logic [IDX_W-1:0] mem_addr;
    logic [7:0]       lane_we;
    logic [63:0]      lane_wdata;

    logic [63:0]       ram_dout_q, host_rdata_q;
    logic              err_flag_q;
    logic [ADDR_W-1:0] err_addr_q;

    assign funct3   = ram_ctrl[CTRL_F3_HI:CTRL_F3_LO];
    assign valid    = ram_ctrl[CTRL_VALID];
    assign is_write = ram_ctrl[CTRL_WRITE];
    assign zext     = funct3[2];
    assign size     = size_e'(funct3[1:0]);
    assign off      = ram_addr[2:0];
    assign idx      = ram_addr[IDX_W+2:3];

    assign size_bytes   = 4'd1 << size;
    assign align_mask   = 3'(size_bytes - 4'd1);
    assign misaligned   = |(off & align_mask);
    assign out_of_range = |ram_addr[ADDR_W-1:IDX_W+3];
    assign bad_funct3   = is_write ? funct3[2] : (funct3 == F3_LOAD_ILLEGAL);
    assign fault        = valid && (misaligned || out_of_range || bad_funct3);

    assign core_store = valid &&  is_write && !fault;
    assign core_load  = valid && !is_write && !fault;
    // Core traffic always wins; a host request in the same cycle is dropped.
    assign host_act   = !running && host_en && !valid;

    assign byte_mask  = 8'((9'd1 << size_bytes) - 9'd1);
    assign lane_mask  = byte_mask << off;
    assign store_data = ram_din << {off, 3'b000};

    // NOTE: every signal gets a default before the branches so this block can
    // never infer a latch.
    always_comb begin
        mem_addr   = valid ? idx : host_addr;
        lane_we    = '0;
        lane_wdata = store_data;
        if (core_store) begin
            lane_we = lane_mask;
        end else if (host_act && host_we) begin
            lane_we    = '1;
            lane_wdata = host_wdata;
        end
        if (!rst_n) begin
            lane_we = '0;
        end
    end

    for (genvar b = 0; b < 8; b++) begin : g_lane
        cpu_dmem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
            .clk     (clk),
            .we_i    (lane_we[b]),
            .addr_i  (mem_addr),
            .wdata_i (lane_wdata[8*b +: 8]),
            .rdata_o (rd_data[8*b +: 8])
        );
    end

    assign load_ext = extend_load(rd_data >> {off, 3'b000}, size, zext);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_dout_q   <= '0;
            host_rdata_q <= '0;
            err_flag_q   <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            if (core_load) begin
                ram_dout_q <= load_ext;
            end else if (fault && !is_write) begin
                ram_dout_q <= '0;
            end
            if (host_act && !host_we) begin
                host_rdata_q <= rd_data;
            end
            // A new fault beats a simultaneous clear and re-captures its address.
            if (fault && (!err_flag_q || err_clr)) begin
                err_flag_q <= 1'b1;
                err_addr_q <= ram_addr;
            end else if (err_clr) begin
                err_flag_q <= 1'b0;
                err_addr_q <= '0;
            end
        end
    end

    assign ram_dout   = ram_dout_q;
    assign host_rdata = host_rdata_q;
    assign err_flag   = err_flag_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_cpu_dmem.sv
// Self-checking bench for cpu_dmem: directed scenarios plus randomized core traffic
// compared against a byte-array reference model.
module tb_cpu_dmem;

    localparam int DEPTH     = 512;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * 8;

    logic              clk;
    logic              rst_n;
    logic              running;
    logic [4:0]        ram_ctrl;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_din;
    logic [63:0]       ram_dout;
    logic              host_en;
    logic              host_we;
    logic [IDX_W-1:0]  host_addr;
    logic [63:0]       host_wdata;
    logic [63:0]       host_rdata;
    logic              err_flag;
    logic [ADDR_W-1:0] err_addr;
    logic              err_clr;

    cpu_dmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .running(running), .ram_ctrl(ram_ctrl),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]        model_mem [MEM_BYTES];
    logic [63:0]       exp_dout   = '0;
    logic [63:0]       exp_hrdata = '0;
    logic              exp_flag   = 1'b0;
    logic [ADDR_W-1:0] exp_eaddr  = '0;

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_fault(input logic [2:0] f3, input logic wr, input logic [31:0] addr);
        int sz = size_of(f3);
        if (addr >= 32'(MEM_BYTES)) return 1'b1;
        if ((int'(addr[2:0]) % sz) != 0) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        if (!wr && f3 == 3'b111) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [63:0] v  = '0;
        int          sz = size_of(f3);
        for (int i = 0; i < sz; i++) v = v | (64'(model_mem[addr + i]) << (8 * i));
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
        return v;
    endfunction

    task automatic core_op(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                           input logic [63:0] din, input logic clr);
        bit f = is_fault(f3, wr, addr);
        int sz = size_of(f3);
        ram_ctrl = {f3, wr, 1'b1};
        ram_addr = addr;
        ram_din  = din;
        err_clr  = clr;
        @(posedge clk); #1;
        ram_ctrl = '0;
        ram_addr = 'x;
        ram_din  = 'x;
        err_clr  = 1'b0;
        if (!f && wr)  for (int i = 0; i < sz; i++) model_mem[addr + i] = din[8*i +: 8];
        if (!f && !wr) exp_dout = model_load(f3, addr);
        if (f && !wr)  exp_dout = '0;
        if (f && (!exp_flag || clr)) begin
            exp_flag  = 1'b1;
            exp_eaddr = addr;
        end else if (clr) begin
            exp_flag  = 1'b0;
            exp_eaddr = '0;
        end
    endtask

    task automatic idle_clr(input logic clr);
        ram_ctrl = '0;
        err_clr  = clr;
        @(posedge clk); #1;
        err_clr  = 1'b0;
        if (clr) begin
            exp_flag  = 1'b0;
            exp_eaddr = '0;
        end
    endtask

    task automatic host_op(input logic we, input logic [IDX_W-1:0] idx, input logic [63:0] wd);
        host_en    = 1'b1;
        host_we    = we;
        host_addr  = idx;
        host_wdata = wd;
        @(posedge clk); #1;
        host_en = 1'b0;
        host_we = 1'b0;
        if (!running) begin
            if (we) for (int i = 0; i < 8; i++) model_mem[idx*8 + i] = wd[8*i +: 8];
            else    for (int i = 0; i < 8; i++) exp_hrdata[8*i +: 8] = model_mem[idx*8 + i];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ram_dout !== 64'd0)   begin errors++; $display("FAIL reset_dout: got %h want 0", ram_dout); end
        checks++; if (host_rdata !== 64'd0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", host_rdata); end
        checks++; if (err_flag !== 1'b0)    begin errors++; $display("FAIL reset_flag: got %b want 0", err_flag); end
        checks++; if (err_addr !== 32'd0)   begin errors++; $display("FAIL reset_eaddr: got %h want 0", err_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_preload;
        running = 1'b0;
        for (int i = 0; i < DEPTH; i++) host_op(1'b1, IDX_W'(i), {$urandom, $urandom});
        for (int k = 0; k < 4; k++) begin
            host_op(1'b0, IDX_W'($urandom_range(0, DEPTH - 1)), '0);
            checks++; if (host_rdata !== exp_hrdata) begin errors++; $display("FAIL preload_read: got %h want %h", host_rdata, exp_hrdata); end
        end
        running = 1'b1;
    endtask

    task automatic test_load_store;
        core_op(3'b011, 1'b1, 32'h10, 64'h1122334455667788, 1'b0);
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        checks++; if (ram_dout !== 64'h1122334455667788) begin errors++; $display("FAIL ld_after_sd: got %h want 1122334455667788", ram_dout); end
        core_op(3'b000, 1'b1, 32'h13, 64'hABCDEF0123456780, 1'b0);
        core_op(3'b000, 1'b0, 32'h13, '0, 1'b0);
        checks++; if (ram_dout !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_sign: got %h want ffffffffffffff80", ram_dout); end
        core_op(3'b100, 1'b0, 32'h13, '0, 1'b0);
        checks++; if (ram_dout !== 64'h80) begin errors++; $display("FAIL lbu_zero: got %h want 80", ram_dout); end
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        checks++; if (ram_dout !== 64'h1122334480667788) begin errors++; $display("FAIL sb_lane: got %h want 1122334480667788", ram_dout); end
    endtask

    task automatic test_faults;
        core_op(3'b010, 1'b0, 32'h16, '0, 1'b0);
        checks++; if (ram_dout !== 64'd0)  begin errors++; $display("FAIL misalign_dout: got %h want 0", ram_dout); end
        checks++; if (err_flag !== 1'b1)   begin errors++; $display("FAIL misalign_flag: got %b want 1", err_flag); end
        checks++; if (err_addr !== 32'h16) begin errors++; $display("FAIL misalign_eaddr: got %h want 16", err_addr); end
        core_op(3'b010, 1'b1, 32'h22, 64'h5555, 1'b0);
        checks++; if (err_addr !== 32'h16) begin errors++; $display("FAIL sticky_eaddr: got %h want 16", err_addr); end
        idle_clr(1'b1);
        checks++; if (err_flag !== 1'b0 || err_addr !== 32'd0) begin errors++; $display("FAIL err_clr: got %b/%h want 0/0", err_flag, err_addr); end
        core_op(3'b011, 1'b0, 32'h31, '0, 1'b0);
        core_op(3'b001, 1'b0, 32'h45, '0, 1'b1);
        checks++; if (err_flag !== 1'b1 || err_addr !== 32'h45) begin errors++; $display("FAIL clr_vs_fault: got %b/%h want 1/45", err_flag, err_addr); end
        core_op(3'b111, 1'b0, 32'h40, '0, 1'b1);
        checks++; if (err_addr !== 32'h40) begin errors++; $display("FAIL ld_f3_111: got %h want 40", err_addr); end
        core_op(3'b110, 1'b1, 32'h48, '0, 1'b1);
        checks++; if (err_addr !== 32'h48) begin errors++; $display("FAIL st_f3_110: got %h want 48", err_addr); end
        idle_clr(1'b1);
    endtask

    task automatic test_back_to_back;
        core_op(3'b010, 1'b1, 32'h20, 64'h12345678CAFEBABE, 1'b0);
        core_op(3'b010, 1'b0, 32'h20, '0, 1'b0);
        checks++; if (ram_dout !== 64'hFFFFFFFFCAFEBABE) begin errors++; $display("FAIL b2b_lw: got %h want ffffffffcafebabe", ram_dout); end
        core_op(3'b110, 1'b0, 32'h20, '0, 1'b0);
        checks++; if (ram_dout !== 64'h00000000CAFEBABE) begin errors++; $display("FAIL b2b_lwu: got %h want cafebabe", ram_dout); end
        ram_addr = 'x;
        idle_clr(1'b0);
        idle_clr(1'b0);
        checks++; if (ram_dout !== 64'h00000000CAFEBABE) begin errors++; $display("FAIL idle_hold: got %h want cafebabe", ram_dout); end
        core_op(3'b010, 1'b1, 32'h24, 64'h1, 1'b0);
        checks++; if (ram_dout !== 64'h00000000CAFEBABE) begin errors++; $display("FAIL store_hold: got %h want cafebabe", ram_dout); end
    endtask

    task automatic test_host;
        running = 1'b0;
        host_op(1'b1, IDX_W'(5), 64'hDEADBEEFCAFEF00D);
        host_op(1'b0, IDX_W'(5), '0);
        checks++; if (host_rdata !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL host_rd: got %h want deadbeefcafef00d", host_rdata); end
        core_op(3'b101, 1'b0, 32'h2E, '0, 1'b0);
        checks++; if (ram_dout !== 64'hDEAD) begin errors++; $display("FAIL lhu_2e: got %h want dead", ram_dout); end
        core_op(3'b101, 1'b0, 32'h2A, '0, 1'b0);
        checks++; if (ram_dout !== 64'hCAFE) begin errors++; $display("FAIL lhu_2a: got %h want cafe", ram_dout); end
        running = 1'b1;
        host_op(1'b1, IDX_W'(5), 64'd0);
        host_op(1'b0, IDX_W'(0), '0);
        checks++; if (host_rdata !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL host_ignored: got %h want deadbeefcafef00d", host_rdata); end
        core_op(3'b011, 1'b0, 32'h28, '0, 1'b0);
        checks++; if (ram_dout !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL host_wr_blocked: got %h want deadbeefcafef00d", ram_dout); end
        running    = 1'b0;
        host_en    = 1'b1;
        host_we    = 1'b1;
        host_addr  = IDX_W'(2);
        host_wdata = 64'd0;
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        host_en = 1'b0;
        host_we = 1'b0;
        checks++; if (ram_dout !== 64'h1122334480667788) begin errors++; $display("FAIL core_priority: got %h want 1122334480667788", ram_dout); end
        host_op(1'b0, IDX_W'(2), '0);
        checks++; if (host_rdata !== 64'h1122334480667788) begin errors++; $display("FAIL host_dropped: got %h want 1122334480667788", host_rdata); end
        running = 1'b1;
    endtask

    task automatic test_out_of_range;
        core_op(3'b011, 1'b0, 32'(MEM_BYTES), '0, 1'b0);
        checks++; if (ram_dout !== 64'd0 || err_flag !== 1'b1) begin errors++; $display("FAIL oor_load: got %h/%b want 0/1", ram_dout, err_flag); end
        checks++; if (err_addr !== 32'(MEM_BYTES)) begin errors++; $display("FAIL oor_eaddr: got %h want %h", err_addr, 32'(MEM_BYTES)); end
        core_op(3'b011, 1'b1, 32'(MEM_BYTES) + 32'h10, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        checks++; if (ram_dout !== 64'h1122334480667788) begin errors++; $display("FAIL oor_no_write: got %h want 1122334480667788", ram_dout); end
        idle_clr(1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            logic        wr  = 1'($urandom_range(0, 1));
            int          sz  = size_of(f3);
            int          c   = $urandom_range(0, 19);
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) begin
                idle_clr(1'($urandom_range(0, 1)));
            end else begin
                if (c == 0)      a = 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
                else if (c == 1) a = 32'($urandom_range(0, MEM_BYTES - 1));
                else             a = 32'($urandom_range(0, 255)) & ~32'(sz - 1);
                core_op(f3, wr, a, {$urandom, $urandom}, $urandom_range(0, 9) == 0);
            end
            checks++; if (ram_dout !== exp_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h want %h", n, ram_dout, exp_dout); end
            checks++; if (err_flag !== exp_flag || err_addr !== exp_eaddr) begin
                errors++; $display("FAIL rand_err[%0d]: got %b/%h want %b/%h", n, err_flag, err_addr, exp_flag, exp_eaddr);
            end
        end
    endtask

    task automatic test_reset_mid;
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        core_op(3'b011, 1'b0, 32'h13, '0, 1'b0);
        rst_n    = 1'b0;
        ram_ctrl = {3'b011, 1'b0, 1'b1};
        ram_addr = 32'h10;
        @(posedge clk); #1;
        ram_ctrl = '0;
        exp_dout = '0; exp_hrdata = '0; exp_flag = 1'b0; exp_eaddr = '0;
        checks++; if (ram_dout !== 64'd0) begin errors++; $display("FAIL mid_reset_dout: got %h want 0", ram_dout); end
        checks++; if (err_flag !== 1'b0 || err_addr !== 32'd0 || host_rdata !== 64'd0) begin
            errors++; $display("FAIL mid_reset_regs: got %b/%h/%h want 0/0/0", err_flag, err_addr, host_rdata);
        end
        rst_n = 1'b1;
        core_op(3'b011, 1'b0, 32'h10, '0, 1'b0);
        checks++; if (ram_dout !== exp_dout) begin errors++; $display("FAIL retained: got %h want %h", ram_dout, exp_dout); end
    endtask

    initial begin
        rst_n      = 1'b0;
        running    = 1'b1;
        ram_ctrl   = '0;
        ram_addr   = '0;
        ram_din    = '0;
        host_en    = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        err_clr    = 1'b0;
        test_reset;
        test_preload;
        test_load_store;
        test_faults;
        test_back_to_back;
        test_host;
        test_out_of_range;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
